// File: rtl/dphy_byte_packer_pkg.sv
// Shared capture definitions: packer FSM states and capture-wide widths/constants.
package dphy_byte_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HUNT,
    ST_PACK,
    ST_DONE
  } cap_state_t;

  localparam logic [7:0] CAP_SYNC_BYTE = 8'hB8;
  localparam int         CAP_CNT_W     = 21;

endpackage

// File: rtl/dphy_byte_packer_if.sv
// Byte stream from the D-PHY HS receiver and packed-word stream to storage.
interface dphy_byte_packer_if;
  logic        hs_active;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] data_out;
  logic        data_out_valid;

  modport master (
    input  hs_active, byte_in, byte_valid,
    output data_out, data_out_valid
  );

  modport slave (
    output hs_active, byte_in, byte_valid,
    input  data_out, data_out_valid
  );
endinterface

// File: rtl/dphy_byte_packer.sv
// Finds the sync leader of each HS burst and packs payload bytes little-endian
// into 32-bit words for storage; stops after CAPTURE_WORDS words.
module dphy_byte_packer
  import dphy_byte_packer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = CAP_SYNC_BYTE,
  parameter int         CAPTURE_WORDS = 65536,
  parameter int         CNT_W         = CAP_CNT_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               arm,
  dphy_byte_packer_if.master lane,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   word_count,
  output logic [7:0]         sync_err_count
);

  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAPTURE_WORDS - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  cap_state_t  state, state_nxt;
  logic        hs_active_p1;
  logic [1:0]  byte_idx, idx_nxt, idx_acc;
  logic [31:0] word_buf, buf_nxt, word_acc;
  logic        emit, err_inc, clr_count;
  logic        hs_rise, last_word;

  assign hs_rise   = lane.hs_active & ~hs_active_p1;
  assign last_word = (word_count == CAP_LAST);
  assign busy      = (state == ST_ARMED) || (state == ST_HUNT) || (state == ST_PACK);

  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    buf_nxt   = word_buf;
    word_acc  = word_buf;
    idx_acc   = byte_idx;
    emit      = 1'b0;
    err_inc   = 1'b0;
    clr_count = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm) begin
          state_nxt = ST_ARMED;
          clr_count = 1'b1;
        end
      end
      ST_ARMED: begin
        if (hs_rise) state_nxt = ST_HUNT;
      end
      ST_HUNT: begin
        if (lane.byte_valid) begin
          if (lane.byte_in == SYNC_BYTE) begin
            state_nxt = ST_PACK;
            idx_nxt   = 2'd0;
            buf_nxt   = '0;
          end else begin
            err_inc   = 1'b1;
            state_nxt = ST_ARMED;
          end
        end else if (!lane.hs_active) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_PACK: begin
        // A byte arriving with the falling hs_active is merged before any flush.
        if (lane.byte_valid) begin
          word_acc[{byte_idx, 3'b000} +: 8] = lane.byte_in;
          idx_acc = byte_idx + 2'd1;
        end
        if (lane.byte_valid && (byte_idx == 2'd3)) emit = 1'b1;
        else if (!lane.hs_active && (idx_acc != 2'd0)) emit = 1'b1;
        if (emit) begin
          buf_nxt = '0;
          idx_nxt = 2'd0;
        end else begin
          buf_nxt = word_acc;
          idx_nxt = idx_acc;
        end
        if (emit && last_word) begin
          state_nxt = ST_DONE;
        end else if (!lane.hs_active) begin
          state_nxt = ST_ARMED;
          idx_nxt   = 2'd0;
          buf_nxt   = '0;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered state, edge detector and word strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state               <= ST_IDLE;
      hs_active_p1        <= 1'b0;
      byte_idx            <= 2'd0;
      word_buf            <= '0;
      lane.data_out       <= '0;
      lane.data_out_valid <= 1'b0;
      done                <= 1'b0;
      word_count          <= '0;
      sync_err_count      <= '0;
    end else begin
      state               <= state_nxt;
      hs_active_p1        <= lane.hs_active;
      byte_idx            <= idx_nxt;
      word_buf            <= buf_nxt;
      lane.data_out_valid <= emit;
      if (emit) lane.data_out <= word_acc;
      done                <= (state == ST_DONE);
      if (clr_count) word_count <= '0;
      else if (emit) word_count <= word_count + 1'b1;
      if (err_inc) sync_err_count <= sat_inc8(sync_err_count);
    end
  end

endmodule

// File: tb/tb_dphy_byte_packer.sv
// Directed bench for dphy_byte_packer with a three-word capture limit.
module tb_dphy_byte_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        arm;
  logic        busy, done;
  logic [20:0] word_count;
  logic [7:0]  sync_err_count;

  int passed = 0;
  int total  = 0;
  logic [31:0] got_q[$];
  int done_seen = 0;

  dphy_byte_packer_if bus();

  dphy_byte_packer #(
    .SYNC_BYTE    (8'hB8),
    .CAPTURE_WORDS(3),
    .CNT_W        (21)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .arm           (arm),
    .lane          (bus),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count),
    .sync_err_count(sync_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (bus.data_out_valid === 1'b1) got_q.push_back(bus.data_out);
    if (done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    arm = 1'b0; bus.hs_active = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    sys_rst_n = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    got_q.delete();
    done_seen = 0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic start_burst();
    bus.hs_active = 1'b1; tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1; bus.byte_in = b; tick(); bus.byte_valid = 1'b0;
  endtask

  task automatic end_burst();
    bus.hs_active = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.data_out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", bus.data_out_valid); else passed++;
    total++; if (bus.data_out !== 32'h0) $display("FAIL rst_data: got %h expected 0", bus.data_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else passed++;
    total++; if (word_count !== 21'd0) $display("FAIL rst_count: got %0d expected 0", word_count); else passed++;
    total++; if (sync_err_count !== 8'd0) $display("FAIL rst_err: got %0d expected 0", sync_err_count); else passed++;
  endtask

  task automatic test_two_words();
    do_reset();
    pulse_arm();
    total++; if (busy !== 1'b1) $display("FAIL arm_busy: got %b expected 1", busy); else passed++;
    start_burst();
    send_byte(8'hB8);
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i));
      if (i == 4) begin
        total++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== 32'h04030201)
          $display("FAIL word0_latency: got vld=%b data=%h expected vld=1 data=04030201", bus.data_out_valid, bus.data_out);
        else passed++;
      end
    end
    end_burst(); tick(); tick();
    total++; if (got_q.size() !== 2) $display("FAIL two_words_cnt: got %0d strobes expected 2", got_q.size()); else passed++;
    if (got_q.size() >= 2) begin
      total++; if (got_q[1] !== 32'h08070605) $display("FAIL word1: got %h expected 08070605", got_q[1]); else passed++;
    end
    total++; if (word_count !== 21'd2) $display("FAIL two_words_wc: got %0d expected 2", word_count); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL rearmed_busy: got %b expected 1", busy); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    pulse_arm();
    start_burst();
    send_byte(8'hB8); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    total++; if (bus.data_out_valid !== 1'b0) $display("FAIL flush_early: got vld=%b expected 0", bus.data_out_valid); else passed++;
    end_burst();
    total++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 32'h00CCBBAA)
      $display("FAIL flush_word: got vld=%b data=%h expected vld=1 data=00CCBBAA", bus.data_out_valid, bus.data_out);
    else passed++;
    tick();
    total++; if (bus.data_out_valid !== 1'b0) $display("FAIL flush_one_cycle: got vld=%b expected 0", bus.data_out_valid); else passed++;
    total++; if (word_count !== 21'd1) $display("FAIL flush_wc: got %0d expected 1", word_count); else passed++;
  endtask

  task automatic test_same_cycle_end();
    do_reset();
    pulse_arm();
    start_burst();
    send_byte(8'hB8); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    bus.hs_active = 1'b0; send_byte(8'h04);
    total++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 32'h04030201)
      $display("FAIL end_full_word: got vld=%b data=%h expected vld=1 data=04030201", bus.data_out_valid, bus.data_out);
    else passed++;
    tick();
    total++; if (bus.data_out_valid !== 1'b0) $display("FAIL end_no_extra_flush: got vld=%b expected 0", bus.data_out_valid); else passed++;
    start_burst();
    send_byte(8'hB8); send_byte(8'h21); send_byte(8'h22);
    bus.hs_active = 1'b0; send_byte(8'h23);
    total++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 32'h00232221)
      $display("FAIL end_partial_flush: got vld=%b data=%h expected vld=1 data=00232221", bus.data_out_valid, bus.data_out);
    else passed++;
    tick();
    total++; if (got_q.size() !== 2) $display("FAIL end_strobe_cnt: got %0d expected 2", got_q.size()); else passed++;
  endtask

  task automatic test_sync_err();
    do_reset();
    pulse_arm();
    start_burst();
    send_byte(8'h55);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    end_burst(); tick();
    total++; if (got_q.size() !== 0) $display("FAIL bad_sync_words: got %0d expected 0", got_q.size()); else passed++;
    total++; if (sync_err_count !== 8'd1) $display("FAIL bad_sync_err: got %0d expected 1", sync_err_count); else passed++;
    start_burst();
    send_byte(8'hB8); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    end_burst(); tick();
    total++; if (got_q.size() !== 1) $display("FAIL good_after_bad_cnt: got %0d expected 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 32'h44332211) $display("FAIL good_after_bad_word: got %h expected 44332211", got_q[0]); else passed++;
    end
    total++; if (sync_err_count !== 8'd1) $display("FAIL err_held: got %0d expected 1", sync_err_count); else passed++;
  endtask

  task automatic test_capacity();
    do_reset();
    pulse_arm();
    start_burst();
    send_byte(8'hB8);
    for (int i = 1; i <= 16; i++) begin
      send_byte(8'(i));
      if (i == 12) begin
        total++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== 32'h0C0B0A09)
          $display("FAIL cap_last_word: got vld=%b data=%h expected vld=1 data=0C0B0A09", bus.data_out_valid, bus.data_out);
        else passed++;
      end
      if (i == 13) begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
          $display("FAIL cap_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        else passed++;
      end
    end
    end_burst(); tick();
    total++; if (got_q.size() !== 3) $display("FAIL cap_strobes: got %0d expected 3", got_q.size()); else passed++;
    total++; if (word_count !== 21'd3) $display("FAIL cap_wc: got %0d expected 3", word_count); else passed++;
    total++; if (done_seen !== 1) $display("FAIL cap_done_pulses: got %0d expected 1", done_seen); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cap_idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_mid_burst_arm();
    do_reset();
    start_burst();
    pulse_arm();
    send_byte(8'hB8);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    end_burst(); tick();
    total++; if (got_q.size() !== 0) $display("FAIL midburst_ignored: got %0d expected 0", got_q.size()); else passed++;
    start_burst();
    send_byte(8'hB8); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    end_burst(); tick();
    total++; if (got_q.size() !== 1) $display("FAIL next_burst_cnt: got %0d expected 1", got_q.size()); else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 32'hA4A3A2A1) $display("FAIL next_burst_word: got %h expected A4A3A2A1", got_q[0]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_arm();
    start_burst();
    send_byte(8'hB8); send_byte(8'h11); send_byte(8'h22);
    sys_rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus.data_out_valid !== 1'b0 || bus.data_out !== 32'h0 || done !== 1'b0 ||
        word_count !== 21'd0 || sync_err_count !== 8'd0)
      $display("FAIL async_reset: got busy=%b vld=%b data=%h done=%b wc=%0d err=%0d expected all 0",
               busy, bus.data_out_valid, bus.data_out, done, word_count, sync_err_count);
    else passed++;
    send_byte(8'h33); send_byte(8'h44);
    sys_rst_n = 1'b1;
    end_burst(); tick();
    total++; if (got_q.size() !== 0) $display("FAIL reset_lost_word: got %0d strobes expected 0", got_q.size()); else passed++;
    pulse_arm();
    start_burst();
    send_byte(8'hB8); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    end_burst(); tick();
    total++;
    if (got_q.size() !== 1 || word_count !== 21'd1)
      $display("FAIL rearm_capture: got strobes=%0d wc=%0d expected 1/1", got_q.size(), word_count);
    else passed++;
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 32'h04030201) $display("FAIL rearm_word: got %h expected 04030201", got_q[0]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_flush();
    test_same_cycle_end();
    test_sync_err();
    test_capacity();
    test_mid_burst_arm();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dphy_byte_packer.md
# dphy_byte_packer

Capture-side packer between the single-lane D-PHY HS byte receiver and `data_storage_controller`. Once armed by `cmd_record`, it finds the sync byte at the start of each HS burst and packs the payload bytes little-endian into 32-bit words. It drives the storage `data_in`/`data_in_valid` pair and stops after a fixed number of words. Storage has no backpressure, so this block never stalls.

## Interface
- `SYNC_BYTE`, 8'hB8, leader byte expected as first valid byte of every HS burst
- `CAPTURE_WORDS`, 65536, words stored per capture (1..2^21-1)
- `CNT_W`, 21, width of word counter
- `sys_clk` in 1: clock, same domain as byte receiver output
- `sys_rst_n` in 1: reset, asynchronous, active-low
- `arm` in 1: single-cycle start pulse (from `cmd_record`)
- `hs_active` in 1: high while lane is in an HS burst
- `byte_in` in 8: received HS byte
- `byte_valid` in 1: `byte_in` valid this cycle
- `data_out` out 32: packed word to storage `data_in`
- `data_out_valid` out 1: one-cycle word strobe to storage `data_in_valid`
- `busy` out 1: capture in progress (ARMED/HUNT/PACK)
- `done` out 1: one-cycle pulse when `CAPTURE_WORDS` reached
- `word_count` out CNT_W: words emitted in current capture
- `sync_err_count` out 8: saturating count of bursts rejected for a bad leader

## Operation
- States: IDLE, ARMED, HUNT, PACK, DONE.
- IDLE: `arm` clears `word_count` and moves to ARMED. `arm` in any other state is ignored.
- ARMED: the first rising edge of `hs_active` moves to HUNT. The block never starts mid-burst.
- HUNT: the first valid byte of the burst is checked.
  - If it equals `SYNC_BYTE`: go to PACK. The byte is dropped.
  - Otherwise: `sync_err_count`+1 (saturate 255) and return to ARMED to wait for the next burst.
- PACK: each valid byte goes into lane slot `byte_idx` (0..3). Byte 0 lands in `data_out[7:0]`.
  - On the 4th byte, the word is emitted and `byte_idx` returns to 0.
- End of burst: `hs_active` falls in PACK.
  - If `byte_idx`≠0: flush the partial word with unused upper bytes zero.
  - Then go to ARMED for the next burst.
- Capacity: when the emitted word makes `word_count`==`CAPTURE_WORDS`, go to DONE. Remaining bytes of the burst are discarded.
- DONE: pulse `done` for 1 cycle, then go to IDLE. `word_count` holds its value until the next `arm`.
- `word_count` increments by exactly 1 per `data_out_valid` and never exceeds `CAPTURE_WORDS`.
- `busy` is high in ARMED, HUNT and PACK.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `busy`=0, `done`=0, `word_count`=0, `sync_err_count`=0. State=IDLE, `byte_idx`=0.
- Word latency: `data_out_valid` is high the cycle after the 4th byte is sampled. `data_out` is stable only while valid is high; it is don't-care otherwise.
- `busy` rises the cycle after `arm`.
- Flush: `data_out_valid` is high the cycle after `hs_active` is sampled low.
- Byte and burst end in the same cycle (`byte_valid` with `hs_active` falling): the byte is accepted first.
  - If it completes a word, that word is emitted with no extra flush.
  - Otherwise the flush includes it.
- Throughput: 1 byte/cycle sustained, so at most 1 word every 4 cycles.
- `done` is high the cycle after the final `data_out_valid`.
- Asynchronous reset mid-capture: all state and outputs return to reset values immediately. A partial word is lost and no strobe is emitted.

## Structure
- Shared capture package: state enum, `SYNC_BYTE` default, `CNT_W`. These are reused by `uart_protocol_processor` for address width.
- No sub-module. The HS edge detector (one register on `hs_active`) is inline.

## Test plan
- Arm; send one burst B8,01,02,03,04,05,06,07,08, then drop `hs_active` -> words 0x04030201, 0x08070605; no flush strobe; `word_count`=2.
- Burst B8,AA,BB,CC, then drop -> flush word 0x00CCBBAA one cycle after the drop.
- Burst starting 0x55 -> no words; `sync_err_count`=1. A following good burst is captured normally.
- `CAPTURE_WORDS`=3; burst of sync plus 16 bytes -> exactly 3 strobes, `done` one cycle after the third, `busy` low, remaining bytes ignored.
- Burst already active when `arm` arrives -> that burst is ignored; the capture starts on the next rising edge of `hs_active`.
- Assert reset after 2 bytes of a word -> no strobe, all outputs 0. A re-arm after release captures cleanly.
